// File: rtl/cordic_req_ctrl.sv
// Request initiator / result collector for the pipelined CORDIC core.
// Feeds the core one request per cycle and gathers its results into a credit-guarded FWFT FIFO.
module cordic_req_ctrl #(
  parameter int WIDTH      = 19,
  parameter int LATENCY    = 25,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [1:0]                    s_op,
  input  logic [WIDTH-1:0]              s_x,
  input  logic [WIDTH-1:0]              s_y,
  input  logic [WIDTH:0]                s_phase,
  input  logic [TAG_W-1:0]              s_tag,
  output logic [1:0]                    c_op,
  output logic [WIDTH-1:0]              c_x,
  output logic [WIDTH-1:0]              c_y,
  output logic [WIDTH:0]                c_phase,
  input  logic [WIDTH-1:0]              c_xout,
  input  logic [WIDTH-1:0]              c_yout,
  input  logic [WIDTH:0]                c_phaseout,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [WIDTH-1:0]              m_x,
  output logic [WIDTH-1:0]              m_y,
  output logic [WIDTH:0]                m_phase,
  output logic [TAG_W-1:0]              m_tag,
  output logic [$clog2(FIFO_DEPTH):0]   credits,
  output logic                          err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = WIDTH + 1;
  localparam int EW = 2 * WIDTH + PW + TAG_W;

  logic             accept;
  logic             pop;
  logic             push;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [EW-1:0]    pushEntry;

  logic [1:0]       cOp_q, cOp_d;
  logic [WIDTH-1:0] cX_q, cX_d;
  logic [WIDTH-1:0] cY_q, cY_d;
  logic [PW-1:0]    cPhase_q, cPhase_d;

  logic             dlValid_q [LATENCY+1];
  logic [TAG_W-1:0] dlTag_q   [LATENCY+1];

  logic [EW-1:0]    fifoMem_q [FIFO_DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;

  logic [CW-1:0]    credits_q, credits_d;
  logic             err_q, err_d;
  logic             accPrev_q, accPrev_d;

  assign s_ready   = rst_n && (credits_q != '0);
  assign accept    = s_valid && s_ready;
  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
  assign m_valid   = !fifoEmpty;
  assign pop       = m_valid && m_ready;
  assign push      = dlValid_q[LATENCY];
  assign pushEntry = {c_xout, c_yout, c_phaseout, dlTag_q[LATENCY]};

  assign {m_x, m_y, m_phase, m_tag} = fifoMem_q[rdPtr_q[AW-1:0]];

  assign c_op    = cOp_q;
  assign c_x     = cX_q;
  assign c_y     = cY_q;
  assign c_phase = cPhase_q;
  assign credits = credits_q;
  assign err     = err_q;

  // Core inputs carry a request only on its accept edge; idle slots feed a zero vector.
  always_comb begin
    cOp_d    = 2'd0;
    cX_d     = '0;
    cY_d     = '0;
    cPhase_d = '0;
    if (accept) begin
      cOp_d    = s_op;
      cX_d     = s_x;
      cY_d     = s_y;
      cPhase_d = s_phase;
    end
  end

  // Credits cover every in-flight slot plus every buffered result, so a push can never overflow.
  always_comb begin
    credits_d = credits_q;
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    accPrev_d = accept;
    err_d     = err_q;
    if (accept && !pop) begin
      credits_d = credits_q - CW'(1);
    end else if (pop && !accept) begin
      credits_d = credits_q + CW'(1);
    end
    if (push && !fifoFull) begin
      wrPtr_d = wrPtr_q + (AW+1)'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + (AW+1)'(1);
    end
    if (accept && (s_op == 2'd3) && !accPrev_q) begin
      err_d = 1'b1;
    end
    if (accept && (s_op == 2'd2)) begin
      err_d = 1'b1;
    end
    if (push && fifoFull) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cOp_q     <= 2'd0;
      cX_q      <= '0;
      cY_q      <= '0;
      cPhase_q  <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      credits_q <= CW'(FIFO_DEPTH);
      err_q     <= 1'b0;
      accPrev_q <= 1'b0;
    end else begin
      cOp_q     <= cOp_d;
      cX_q      <= cX_d;
      cY_q      <= cY_d;
      cPhase_q  <= cPhase_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      credits_q <= credits_d;
      err_q     <= err_d;
      accPrev_q <= accPrev_d;
    end
  end

  // Valid/tag shadow of the core pipeline; its last stage lines up with the core outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= LATENCY; i++) begin
        dlValid_q[i] <= 1'b0;
        dlTag_q[i]   <= '0;
      end
    end else begin
      dlValid_q[0] <= accept;
      dlTag_q[0]   <= accept ? s_tag : '0;
      for (int i = 1; i <= LATENCY; i++) begin
        dlValid_q[i] <= dlValid_q[i-1];
        dlTag_q[i]   <= dlTag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push && !fifoFull) begin
      fifoMem_q[wrPtr_q[AW-1:0]] <= pushEntry;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && fifoFull));
      assert (credits_q <= CW'(FIFO_DEPTH));
    end
  end

endmodule

// File: doc/cordic_req_ctrl.md
Name: cordic_req_ctrl

Overview:
- Client-side initiator/collector for the team's pipelined CORDIC core (cordicg).
- Accepts tagged requests on a valid/ready stream and drives the core's op/x/y/phase inputs.
- Tracks each request through the fixed-latency pipeline with a valid/tag delay line, then captures core results into an output FIFO with valid/ready backpressure.
- Credit accounting guarantees no in-flight result is ever lost, because the core itself cannot stall.

Parameters:
- WIDTH, 19: core x/y width; phase is WIDTH+1 bits.
- LATENCY, 25: core register stages from input ports to output ports.
- TAG_W, 4: request tag width.
- FIFO_DEPTH, 32: result FIFO entries and initial credit count. Power of 2, ≥2. Full-rate throughput requires ≥ LATENCY+2.

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous, active-low reset
- s_valid  in  1  request valid
- s_ready  out  1  request ready
- s_op  in  2  0 = polar→rect, 1 = rect→polar, 3 = slave (repeat previous rotation directions); 2 is reserved
- s_x, s_y  in  WIDTH  request operands
- s_phase  in  WIDTH+1  request phase
- s_tag  in  TAG_W  request tag
- c_op  out  2  to core opin
- c_x, c_y  out  WIDTH  to core xin/yin
- c_phase  out  WIDTH+1  to core phasein
- c_xout, c_yout  in  WIDTH  from core
- c_phaseout  in  WIDTH+1  from core
- m_valid  out  1  result valid
- m_ready  in  1  result ready
- m_x, m_y  out  WIDTH  result
- m_phase  out  WIDTH+1  result
- m_tag  out  TAG_W  result tag
- credits  out  $clog2(FIFO_DEPTH)+1  free credits
- err  out  1  sticky protocol error

Behaviour:
- Reset is synchronous on rst_n=0. It sets: c_* = 0, delay line cleared, FIFO empty, credits = FIFO_DEPTH, err = 0, m_valid = 0, s_ready = 0 while rst_n=0.
- Accept condition: s_ready = (credits != 0), with s_ready held 0 during reset. A request is accepted on an edge where s_valid & s_ready.
- On accept, c_op/c_x/c_y/c_phase register the request and delay-line stage 0 loads {1, s_tag}.
- On a non-accept edge, c_* register 0 (op=0, zero vector) and stage 0 loads {0, x}. Inputs are never held.
- Delay line is LATENCY+1 stages, valid bit plus tag, shifting every cycle; it never stalls. Its last stage aligns with c_xout/c_yout/c_phaseout belonging to that request.
- When the last stage is valid, FIFO pushes {c_xout, c_yout, c_phaseout, tag} on the next edge.
- Latency: a request accepted on edge k gives m_valid = 1 after edge k+LATENCY+1 when the FIFO was empty (26 cycles at defaults).
- Credits:
  - accept alone decrements;
  - pop alone (m_valid & m_ready) increments;
  - accept and pop on the same edge leave credits unchanged.
  - credits never exceed FIFO_DEPTH and never underflow.
- In-flight count plus FIFO occupancy always equals FIFO_DEPTH − credits, so a push never meets a full FIFO. A push with the FIFO full is an assertion failure, and err is set.
- FIFO is first-word-fall-through: m_* show the head whenever m_valid = 1 and are held stable while m_valid & !m_ready. Results leave in accept order. Push and pop on the same edge are allowed at any occupancy except push-on-full.
- err sets (sticky until reset) when either:
  - s_op = 3 is accepted on an edge that is not immediately preceded by an accept edge, because slave mode needs the adjacent pipeline slot;
  - s_op = 2 is accepted.
- Erroneous requests are still processed and returned.
- Reset mid-operation: all in-flight and buffered results are discarded. The core is not reset and its stale outputs are ignored because the delay line is cleared. The first accept is possible on the first edge with rst_n = 1.
- Tag wrap-around is the client's responsibility; tags are passed through unchanged.

Test Plan:
- Single request, op=1, x=1000, y=0, phase=0, tag=5, with the real core → m_valid first high after edge k+26; m_x = 1647±2, m_y = 0±2, m_phase = 0±2, m_tag = 5, credits returns to 32 after the pop.
- 40 back-to-back requests, tags 0..15 wrapping, m_ready=1 → s_ready never drops; results are contiguous and in order with tags 0..15,0..15,0..7; credits minimum 32−27 = 5.
- m_ready=0, s_valid=1 continuously → exactly 32 accepts, then s_ready=0 and credits=0. One pop → s_ready=1 on the next cycle, and exactly one more accept occurs.
- Pop and accept on the same edge with credits=1 → credits stays 1 and FIFO order is preserved.
- op=3 after an idle cycle → err=1 and stays 1. After reset, op=1 then op=3 on consecutive edges → err stays 0.
- Reset asserted for 1 cycle with 10 requests in flight and 4 buffered → m_valid=0 forever after with no new accepts, and credits=32, s_ready=1, err=0 after the reset edge.
